// File: rtl/note_link_pkg.sv
// Shared types and constants for the note serial link: FSM encoding, frame length, error counter width.
// Frame length grows by one parity bit when PARITY_CHECK_EN is defined.
package note_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  localparam int ERR_CNT_W = 8;

  function automatic int frame_len(input int data_w);
`ifdef PARITY_CHECK_EN
    return data_w + 1;
`else
    return data_w;
`endif
  endfunction

endpackage

// File: rtl/bit_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall pulses
// derived from the synchronized copy only.
module bit_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/note_deserializer.sv
// Serial note-frame receiver: synchronizes sclk/sdata/sframe, shifts a frame MSB first,
// validates its length (and even parity when PARITY_CHECK_EN is defined) and publishes NDATA.
module note_deserializer
  import note_link_pkg::*;
#(
  parameter int DATA_W      = 37,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclk,
  input  logic                 sdata,
  input  logic                 sframe,
  output logic [DATA_W-1:0]    NDATA,
  output logic                 ndata_valid,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [1:0]           o_dbg_state
);

  localparam int FRAME_LEN = frame_len(DATA_W);
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);
  localparam int TO_W      = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_LEN + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  logic w_sclk_rise;
  logic w_sdata;
  logic w_sframe_rise;
  logic w_sframe_fall;
  logic w_unused_sclk_sync;
  logic w_unused_sclk_fall;
  logic w_unused_sdata_rise;
  logic w_unused_sdata_fall;
  logic w_unused_sframe_sync;

  bit_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(sclk),
    .o_sync (w_unused_sclk_sync),
    .o_rise (w_sclk_rise),
    .o_fall (w_unused_sclk_fall)
  );

  bit_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdata (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(sdata),
    .o_sync (w_sdata),
    .o_rise (w_unused_sdata_rise),
    .o_fall (w_unused_sdata_fall)
  );

  bit_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sframe (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(sframe),
    .o_sync (w_unused_sframe_sync),
    .o_rise (w_sframe_rise),
    .o_fall (w_sframe_fall)
  );

  state_t                 r_state;
  logic [FRAME_LEN-1:0]   r_shift;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [TO_W-1:0]        r_to_cnt;

  logic                   w_good;
  logic [DATA_W-1:0]      w_payload;
  logic [ERR_CNT_W-1:0]   w_err_next;

`ifdef PARITY_CHECK_EN
  // Trailing bit makes the whole frame even parity, so a good frame XORs to zero.
  assign w_good    = (r_bit_cnt == CNT_FULL) && !(^r_shift);
  assign w_payload = r_shift[FRAME_LEN-1:1];
`else
  assign w_good    = (r_bit_cnt == CNT_FULL);
  assign w_payload = r_shift;
`endif

  assign w_err_next  = (err_count == '1) ? err_count : err_count + 1'b1;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_to_cnt    <= '0;
      NDATA       <= '0;
      ndata_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_count   <= '0;
    end else begin
      ndata_valid <= 1'b0;
      frame_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_sframe_rise) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_to_cnt  <= '0;
            r_state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_sclk_rise) begin
            r_shift  <= {r_shift[FRAME_LEN-2:0], w_sdata};
            r_to_cnt <= '0;
            if (r_bit_cnt != CNT_SAT) r_bit_cnt <= r_bit_cnt + 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
          // A closing sframe edge wins over a timeout landing in the same cycle.
          if (w_sframe_fall) begin
            r_state <= ST_CHECK;
          end else if (!w_sclk_rise && (r_to_cnt == TO_LAST)) begin
            frame_err <= 1'b1;
            err_count <= w_err_next;
            r_state   <= ST_IDLE;
          end
        end
        ST_CHECK: begin
          if (w_good) begin
            NDATA       <= w_payload;
            ndata_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
            err_count <= w_err_next;
          end
          if (w_sframe_rise) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_to_cnt  <= '0;
            r_state   <= ST_SHIFT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_deserializer.sv
// Directed bench for note_deserializer; covers both the default and PARITY_CHECK_EN builds.
module tb_note_deserializer;

  localparam int DATA_W      = 37;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 4096;
`ifdef PARITY_CHECK_EN
  localparam int FL = DATA_W + 1;
`else
  localparam int FL = DATA_W;
`endif
  localparam int LAT = SYNC_STAGES + 2;

  localparam logic [DATA_W-1:0] PAY_A = 37'h1_2345_6789;
  localparam logic [DATA_W-1:0] PAY_B = 37'h0_F0F0_1234;
  localparam logic [DATA_W-1:0] PAY_C = 37'h1_AAAA_5555;
  localparam logic [DATA_W-1:0] PAY_D = 37'h0_0000_00FF;
  localparam logic [DATA_W-1:0] PAY_E = 37'h1_8000_0001;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sclk = 1'b0;
  logic              sdata = 1'b0;
  logic              sframe = 1'b0;
  logic [DATA_W-1:0] NDATA;
  logic              ndata_valid;
  logic              frame_err;
  logic [7:0]        err_count;
  logic [1:0]        o_dbg_state;

  int checks = 0;
  int failures = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_both = 0;

  note_deserializer #(
    .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .sdata(sdata), .sframe(sframe),
    .NDATA(NDATA), .ndata_valid(ndata_valid), .frame_err(frame_err),
    .err_count(err_count), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / watchdog / pulse monitor ----------------
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog sim_time=%0t limit=3ms", $time);
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk) begin
    if (ndata_valid) n_valid++;
    if (frame_err) n_err++;
    if (ndata_valid && frame_err) n_both++;
  end

  // ---------------- driver tasks ----------------
  function automatic logic [63:0] frame_bits(input logic [DATA_W-1:0] p);
`ifdef PARITY_CHECK_EN
    return {26'd0, p, ^p};
`else
    return {27'd0, p};
`endif
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_open();
    @(negedge clk);
    sframe = 1'b1;
    wait_clk(4);
  endtask

  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      sdata = v[i];
      wait_clk(3);
      sclk = 1'b1;
      wait_clk(3);
      sclk = 1'b0;
    end
    wait_clk(3);
  endtask

  // Drops sframe and reports cycles until the first valid / error pulse (0 = none in 20 cycles).
  task automatic frame_close(output int lat_v, output int lat_e);
    lat_v = 0;
    lat_e = 0;
    @(negedge clk);
    sframe = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ndata_valid && lat_v == 0) lat_v = i;
      if (frame_err && lat_e == 0) lat_e = i;
    end
  endtask

  task automatic send_good(input logic [DATA_W-1:0] p, output int lat_v, output int lat_e);
    frame_open();
    send_bits(frame_bits(p), FL);
    frame_close(lat_v, lat_e);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    wait_clk(3);
    if (NDATA !== '0) begin $display("FAIL reset_ndata got=%h exp=0", NDATA); failures++; end
    checks++;
    if (ndata_valid !== 1'b0 || frame_err !== 1'b0) begin
      $display("FAIL reset_pulses got=%b%b exp=00", ndata_valid, frame_err); failures++;
    end
    checks++;
    if (err_count !== 8'd0) begin $display("FAIL reset_errcnt got=%0d exp=0", err_count); failures++; end
    checks++;
    if (o_dbg_state !== 2'd0) begin $display("FAIL reset_state got=%0d exp=0", o_dbg_state); failures++; end
    checks++;
    @(negedge clk);
    rst_n = 1'b1;
    wait_clk(5);
  endtask

  task automatic test_good_frame();
    int lv, le, v0;
    v0 = n_valid;
    send_good(PAY_A, lv, le);
    if (lv !== LAT || le !== 0) begin
      $display("FAIL good_latency got=%0d/%0d exp=%0d/0", lv, le, LAT); failures++;
    end
    checks++;
    if (NDATA !== PAY_A) begin $display("FAIL good_ndata got=%h exp=%h", NDATA, PAY_A); failures++; end
    checks++;
    if (n_valid - v0 !== 1) begin $display("FAIL good_pulses got=%0d exp=1", n_valid - v0); failures++; end
    checks++;
    if (err_count !== 8'd0) begin $display("FAIL good_errcnt got=%0d exp=0", err_count); failures++; end
    checks++;
  endtask

  task automatic test_short_frame();
    int lv, le;
    frame_open();
    send_bits(64'h9_ABCD_E123, 36);
    frame_close(lv, le);
    if (le !== LAT || lv !== 0) begin
      $display("FAIL short_err_latency got=%0d/%0d exp=%0d/0", le, lv, LAT); failures++;
    end
    checks++;
    if (NDATA !== PAY_A) begin $display("FAIL short_ndata got=%h exp=%h", NDATA, PAY_A); failures++; end
    checks++;
    if (err_count !== 8'd1) begin $display("FAIL short_errcnt got=%0d exp=1", err_count); failures++; end
    checks++;
  endtask

  task automatic test_long_frame();
    int lv, le;
    frame_open();
    send_bits(64'hC3_1234_5678, 40);
    frame_close(lv, le);
    if (le !== LAT || lv !== 0) begin
      $display("FAIL long_err_latency got=%0d/%0d exp=%0d/0", le, lv, LAT); failures++;
    end
    checks++;
    if (NDATA !== PAY_A) begin $display("FAIL long_ndata got=%h exp=%h", NDATA, PAY_A); failures++; end
    checks++;
    if (err_count !== 8'd2) begin $display("FAIL long_errcnt got=%0d exp=2", err_count); failures++; end
    checks++;
  endtask

  task automatic test_timeout();
    int lv, le, e0;
    e0 = n_err;
    frame_open();
    send_bits(64'h2AB, 10);
    wait_clk(TIMEOUT + 100);
    if (n_err - e0 !== 1) begin $display("FAIL timeout_pulse got=%0d exp=1", n_err - e0); failures++; end
    checks++;
    if (o_dbg_state !== 2'd0) begin $display("FAIL timeout_state got=%0d exp=0", o_dbg_state); failures++; end
    checks++;
    send_bits(64'h5, 3);
    frame_close(lv, le);
    if (lv !== 0 || le !== 0) begin
      $display("FAIL timeout_ignored got=%0d/%0d exp=0/0", lv, le); failures++;
    end
    checks++;
    if (err_count !== 8'd3) begin $display("FAIL timeout_errcnt got=%0d exp=3", err_count); failures++; end
    checks++;
    send_good(PAY_B, lv, le);
    if (lv !== LAT || NDATA !== PAY_B) begin
      $display("FAIL timeout_recover got=%0d/%h exp=%0d/%h", lv, NDATA, LAT, PAY_B); failures++;
    end
    checks++;
  endtask

  task automatic test_parity();
    int lv, le;
`ifdef PARITY_CHECK_EN
    frame_open();
    send_bits(frame_bits(PAY_C) ^ 64'd1, FL);
    frame_close(lv, le);
    if (le !== LAT || lv !== 0) begin
      $display("FAIL parity_reject got=%0d/%0d exp=%0d/0", le, lv, LAT); failures++;
    end
    checks++;
    if (NDATA !== PAY_B || err_count !== 8'd4) begin
      $display("FAIL parity_hold got=%h/%0d exp=%h/4", NDATA, err_count, PAY_B); failures++;
    end
    checks++;
`else
    send_good(PAY_C, lv, le);
    if (lv !== LAT || le !== 0) begin
      $display("FAIL noparity_accept got=%0d/%0d exp=%0d/0", lv, le, LAT); failures++;
    end
    checks++;
    if (NDATA !== PAY_C || err_count !== 8'd3) begin
      $display("FAIL noparity_data got=%h/%0d exp=%h/3", NDATA, err_count, PAY_C); failures++;
    end
    checks++;
`endif
  endtask

  task automatic test_back_to_back();
    int lv, le, v0, e0;
    v0 = n_valid;
    e0 = n_err;
    frame_open();
    send_bits(frame_bits(PAY_D), FL);
    @(negedge clk);
    sframe = 1'b0;
    @(negedge clk);
    sframe = 1'b1;
    wait_clk(4);
    send_bits(frame_bits(PAY_E), FL);
    frame_close(lv, le);
    if (n_valid - v0 !== 2 || n_err - e0 !== 0) begin
      $display("FAIL b2b_pulses got=%0d/%0d exp=2/0", n_valid - v0, n_err - e0); failures++;
    end
    checks++;
    if (NDATA !== PAY_E) begin $display("FAIL b2b_ndata got=%h exp=%h", NDATA, PAY_E); failures++; end
    checks++;
  endtask

  task automatic test_reset_mid_frame();
    int lv, le, e0;
    frame_open();
    send_bits(64'hF_0F0F, 20);
    @(negedge clk);
    rst_n = 1'b0;
    sframe = 1'b0;
    wait_clk(3);
    if (NDATA !== '0 || err_count !== 8'd0 || ndata_valid !== 1'b0 || frame_err !== 1'b0) begin
      $display("FAIL midrst_outputs got=%h/%0d/%b/%b exp=0/0/0/0", NDATA, err_count, ndata_valid, frame_err);
      failures++;
    end
    checks++;
    e0 = n_err;
    @(negedge clk);
    rst_n = 1'b1;
    wait_clk(20);
    if (n_err - e0 !== 0 || err_count !== 8'd0) begin
      $display("FAIL midrst_noerr got=%0d/%0d exp=0/0", n_err - e0, err_count); failures++;
    end
    checks++;
    send_good(PAY_A, lv, le);
    if (lv !== LAT || NDATA !== PAY_A) begin
      $display("FAIL midrst_next got=%0d/%h exp=%0d/%h", lv, NDATA, LAT, PAY_A); failures++;
    end
    checks++;
  endtask

  task automatic test_err_saturation();
    int e0;
    e0 = n_err;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      sframe = 1'b1;
      wait_clk(4);
      sframe = 1'b0;
      wait_clk(6);
    end
    if (n_err - e0 !== 300) begin $display("FAIL sat_pulses got=%0d exp=300", n_err - e0); failures++; end
    checks++;
    if (err_count !== 8'd255) begin $display("FAIL sat_errcnt got=%0d exp=255", err_count); failures++; end
    checks++;
    if (NDATA !== PAY_A) begin $display("FAIL sat_ndata got=%h exp=%h", NDATA, PAY_A); failures++; end
    checks++;
  endtask

  task automatic test_exclusive();
    if (n_both !== 0) begin $display("FAIL exclusive_pulses got=%0d exp=0", n_both); failures++; end
    checks++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_short_frame();
    test_long_frame();
    test_timeout();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_err_saturation();
    test_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
